// File: rtl/debounce_pkg.sv
// Shared constants and mode encodings for the multi-channel debouncer.
package debounce_pkg;

    localparam int unsigned DEFAULT_SAMPLE_MAX = 25000;
    localparam int unsigned DEFAULT_PULSE_MAX  = 150;

    typedef enum logic {
        MODE_LEGACY = 1'b0,
        MODE_HYST   = 1'b1
    } mode_e;

endpackage

// File: rtl/debounce_chan.sv
// Single debounce channel: saturating integrator, filtered level and edge pulses.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int PULSE_COUNT_MAX = DEFAULT_PULSE_MAX,
    parameter int SYMMETRIC       = int'(MODE_HYST),
    parameter int CNT_W           = $clog2(PULSE_COUNT_MAX + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic en,
    input  logic in,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PULSE_COUNT_MAX);
    localparam bit HYST = (SYMMETRIC == int'(MODE_HYST));

    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_level_next;

    always_comb begin
        w_cnt_next = r_cnt;
        if (in) begin
            if (r_cnt < CNT_MAX) begin
                w_cnt_next = r_cnt + CNT_W'(1);
            end
        end else if (HYST) begin
            if (r_cnt != '0) begin
                w_cnt_next = r_cnt - CNT_W'(1);
            end
        end else begin
            w_cnt_next = '0;
        end
    end

    // Hysteresis holds the level between the rails; legacy drops it below saturation.
    always_comb begin
        w_level_next = r_level;
        if (w_cnt_next == CNT_MAX) begin
            w_level_next = 1'b1;
        end else if (!HYST || (w_cnt_next == '0)) begin
            w_level_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else if (tick && en) begin
            r_cnt   <= w_cnt_next;
            r_level <= w_level_next;
            r_rise  <= w_level_next & ~r_level;
            r_fall  <= ~w_level_next & r_level;
        end else begin
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end
    end

    assign level = r_level;
    assign rise  = r_rise;
    assign fall  = r_fall;

endmodule

// File: rtl/debouncer_multi.sv
// Multi-channel debouncer: one shared sample-tick counter feeding WIDTH channels.
module debouncer_multi
    import debounce_pkg::*;
#(
    parameter int WIDTH            = 1,
    parameter int SAMPLE_COUNT_MAX = DEFAULT_SAMPLE_MAX,
    parameter int PULSE_COUNT_MAX  = DEFAULT_PULSE_MAX,
    parameter int SYMMETRIC        = int'(MODE_HYST),
    parameter int SAMPLE_W         = $clog2(SAMPLE_COUNT_MAX),
    parameter int CNT_W            = $clog2(PULSE_COUNT_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] glitchy_signal,
    input  logic [WIDTH-1:0] chan_en,
    output logic [WIDTH-1:0] debounced_signal,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             sample_tick
);

    localparam logic [SAMPLE_W-1:0] TICK_LAST = SAMPLE_W'(SAMPLE_COUNT_MAX - 1);

    logic [SAMPLE_W-1:0] r_count;
    logic                w_tick;

    assign w_tick = (r_count == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst || w_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + SAMPLE_W'(1);
        end
    end

    assign sample_tick = w_tick;

    for (genvar g = 0; g < WIDTH; g++) begin : g_chan
        debounce_chan #(
            .PULSE_COUNT_MAX (PULSE_COUNT_MAX),
            .SYMMETRIC       (SYMMETRIC),
            .CNT_W           (CNT_W)
        ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .tick  (w_tick),
            .en    (chan_en[g]),
            .in    (glitchy_signal[g]),
            .level (debounced_signal[g]),
            .rise  (rise_pulse[g]),
            .fall  (fall_pulse[g])
        );
    end

endmodule

// File: tb/tb_debouncer_multi.sv
// Scoreboard bench for debouncer_multi: hysteretic, legacy and default-parameter instances.
module tb_debouncer_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b, rst_c;
    logic [1:0] in_a, en_a, lvl_a, rise_a, fall_a;
    logic       tick_a;
    logic [0:0] in_b, en_b, lvl_b, rise_b, fall_b;
    logic       tick_b;
    logic [0:0] in_c, en_c, lvl_c, rise_c, fall_c;
    logic       tick_c;

    debouncer_multi #(
        .WIDTH (2), .SAMPLE_COUNT_MAX (4), .PULSE_COUNT_MAX (3), .SYMMETRIC (1)
    ) u_a (
        .clk (clk), .rst (rst_a), .glitchy_signal (in_a), .chan_en (en_a),
        .debounced_signal (lvl_a), .rise_pulse (rise_a), .fall_pulse (fall_a),
        .sample_tick (tick_a)
    );

    debouncer_multi #(
        .WIDTH (1), .SAMPLE_COUNT_MAX (4), .PULSE_COUNT_MAX (3), .SYMMETRIC (0)
    ) u_b (
        .clk (clk), .rst (rst_b), .glitchy_signal (in_b), .chan_en (en_b),
        .debounced_signal (lvl_b), .rise_pulse (rise_b), .fall_pulse (fall_b),
        .sample_tick (tick_b)
    );

    debouncer_multi #(
        .WIDTH (1)
    ) u_c (
        .clk (clk), .rst (rst_c), .glitchy_signal (in_c), .chan_en (en_c),
        .debounced_signal (lvl_c), .rise_pulse (rise_c), .fall_pulse (fall_c),
        .sample_tick (tick_c)
    );

    typedef struct {
        int         inst;
        string      name;
        int         cyc;
        logic [1:0] lvl;
        logic [1:0] rise;
        logic [1:0] fall;
        logic       tick;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic push(input int inst, input string name, input int cyc,
                        input logic [1:0] lvl, input logic [1:0] rise,
                        input logic [1:0] fall, input logic tick);
        exp_t e;
        e.inst = inst; e.name = name; e.cyc = cyc;
        e.lvl = lvl; e.rise = rise; e.fall = fall; e.tick = tick;
        exp_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: consumes every queued expectation on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                exp_t       e;
                logic [1:0] a_lvl, a_rise, a_fall;
                logic       a_tick;
                e = exp_q.pop_front();
                case (e.inst)
                    0: begin a_lvl = lvl_a; a_rise = rise_a; a_fall = fall_a; a_tick = tick_a; end
                    1: begin a_lvl = {1'b0, lvl_b}; a_rise = {1'b0, rise_b}; a_fall = {1'b0, fall_b}; a_tick = tick_b; end
                    default: begin a_lvl = {1'b0, lvl_c}; a_rise = {1'b0, rise_c}; a_fall = {1'b0, fall_c}; a_tick = tick_c; end
                endcase
                n_checks++;
                if (a_lvl !== e.lvl || a_rise !== e.rise || a_fall !== e.fall || a_tick !== e.tick) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d: got lvl=%b rise=%b fall=%b tick=%b, expected lvl=%b rise=%b fall=%b tick=%b",
                             e.name, e.cyc, a_lvl, a_rise, a_fall, a_tick, e.lvl, e.rise, e.fall, e.tick);
                end
            end
        end
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        in_a = 2'b00; en_a = 2'b11;
        in_b = 1'b0;  en_b = 1'b1;
        in_c = 1'b0;  en_c = 1'b1;
        next_cycle();

        fork
            // Instance A: hysteretic, 2 channels
            begin
                logic [12:0] pat;
                pat = 13'b1_0101_1000_1111; // window w uses pat[w]
                in_a = 2'b01;
                next_cycle();
                push(0, "a_reset", -1, 2'b00, 2'b00, 2'b00, 1'b0);
                next_cycle();
                rst_a = 1'b0;
                for (int c = 0; c < 52; c++) begin
                    in_a[0] = pat[c / 4];
                    push(0, "a_hyst", c,
                         {1'b0, 1'(c >= 12 && c <= 27)},
                         {1'b0, 1'(c == 12)},
                         {1'b0, 1'(c == 28)},
                         1'(c % 4 == 3));
                    next_cycle();
                end
                rst_a = 1'b1;
                in_a  = 2'b11;
                en_a  = 2'b10;
                next_cycle();
                push(0, "a_reset2", -1, 2'b00, 2'b00, 2'b00, 1'b0);
                next_cycle();
                rst_a = 1'b0;
                for (int c = 0; c < 56; c++) begin
                    en_a[0] = (c >= 43);
                    push(0, "a_enable", c,
                         {1'(c >= 12), 1'(c >= 52)},
                         {1'(c == 12), 1'(c == 52)},
                         2'b00,
                         1'(c % 4 == 3));
                    next_cycle();
                end
            end

            // Instance B: legacy clear-on-low, with off-tick glitches
            begin
                logic [7:0] pat;
                pat = 8'b1011_1011; // window w uses pat[w]
                next_cycle();
                push(1, "b_reset", -1, 2'b00, 2'b00, 2'b00, 1'b0);
                next_cycle();
                rst_b = 1'b0;
                for (int c = 0; c < 32; c++) begin
                    in_b[0] = (c % 4 == 3) ? pat[c / 4] : ~pat[c / 4];
                    push(1, "b_legacy", c,
                         {1'b0, 1'(c >= 24 && c <= 27)},
                         {1'b0, 1'(c == 24)},
                         {1'b0, 1'(c == 28)},
                         1'(c % 4 == 3));
                    next_cycle();
                end
                rst_b = 1'b1;
                in_b  = 1'b1;
                next_cycle();
                next_cycle();
                rst_b = 1'b0;
                for (int c = 0; c < 12; c++) begin
                    rst_b = (c == 11);
                    push(1, "b_pre_rst", c, 2'b00, 2'b00, 2'b00, 1'(c % 4 == 3));
                    next_cycle();
                end
                rst_b = 1'b0;
                for (int c = 0; c < 16; c++) begin
                    push(1, "b_post_rst", c,
                         {1'b0, 1'(c >= 12)},
                         {1'b0, 1'(c == 12)},
                         2'b00,
                         1'(c % 4 == 3));
                    next_cycle();
                end
            end

            // Instance C: default parameters, glitches between ticks
            begin
                next_cycle();
                push(2, "c_reset", -1, 2'b00, 2'b00, 2'b00, 1'b0);
                next_cycle();
                rst_c = 1'b0;
                for (int c = 0; c < 50000; c++) begin
                    in_c[0] = (c % 1000 == 500);
                    push(2, "c_glitch", c, 2'b00, 2'b00, 2'b00, 1'(c % 25000 == 24999));
                    next_cycle();
                end
            end
        join

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
